parking_sensor_conditioner: RTL and testbench

- Upstream front end of the parking controller.
- Synchronises, debounces and edge-detects the raw entry/exit sensors and the 2-bit mode switch.
- Produces clean single-cycle entry/exit event pulses and a stable switch value. These feed the controller's entry_sensor, exit_sensor and switch inputs.
- Arbitrates simultaneous events and enforces a minimum gap between pulses, so the controller never sees both sensors in one cycle.

---
 rtl/parking_sensor_conditioner.sv | 128 ++++++++++++
 tb/tb_parking_sensor_conditioner.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/parking_sensor_conditioner.sv
// Sensor front end for the parking controller: synchronises and debounces the raw
// sensors and mode switch, then issues arbitrated, spaced single-cycle event pulses.
module parking_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_raw,
    input  logic       exit_raw,
    input  logic [1:0] switch_raw,
    output logic       entry_pulse,
    output logic       exit_pulse,
    output logic [1:0] switch_out,
    output logic       entry_pending,
    output logic       exit_pending,
    output logic       overrun
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Bit 3 = entry, bit 2 = exit, bits 1:0 = mode switch.
    logic [3:0]         raw_vec;
    logic [3:0]         sync1_q, sync2_q;
    logic [3:0]         stable_q, stable_d;
    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic [3:0]         rise_c;

    assign raw_vec = {entry_raw, exit_raw, switch_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_deb
            assign stable_d[gi] = (sync2_q[gi] != stable_q[gi]) && (cnt_q[gi] == CNT_LAST)
                                  ? sync2_q[gi] : stable_q[gi];
            assign cnt_d[gi]    = (sync2_q[gi] == stable_q[gi]) || (cnt_q[gi] == CNT_LAST)
                                  ? '0 : cnt_q[gi] + 1'b1;
            assign rise_c[gi]   = stable_d[gi] & ~stable_q[gi];
        end
    endgenerate

    logic          entry_rise, exit_rise;
    logic [0:0]    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          entry_issue, exit_issue;
    logic          entry_pending_q, entry_pending_d;
    logic          exit_pending_q, exit_pending_d;
    logic          entry_pulse_q, exit_pulse_q, overrun_q, overrun_d;

    assign entry_rise = rise_c[3];
    assign exit_rise  = rise_c[2];

    // Exit wins a tie because it frees a slot in the controller.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        entry_issue = 1'b0;
        exit_issue  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exit_pending_q) begin
                    exit_issue = 1'b1;
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end else if (entry_pending_q) begin
                    entry_issue = 1'b1;
                    state_d     = ST_HOLD;
                    hold_cnt_d  = '0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A rise coinciding with issue re-arms the flag instead of counting as overrun.
    assign entry_pending_d = entry_rise | (entry_pending_q & ~entry_issue);
    assign exit_pending_d  = exit_rise  | (exit_pending_q  & ~exit_issue);
    assign overrun_d       = (entry_rise & entry_pending_q & ~entry_issue) |
                             (exit_rise  & exit_pending_q  & ~exit_issue);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            stable_q        <= '0;
            cnt_q           <= '0;
            state_q         <= ST_IDLE;
            hold_cnt_q      <= '0;
            entry_pending_q <= 1'b0;
            exit_pending_q  <= 1'b0;
            entry_pulse_q   <= 1'b0;
            exit_pulse_q    <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            sync1_q         <= raw_vec;
            sync2_q         <= sync1_q;
            stable_q        <= stable_d;
            cnt_q           <= cnt_d;
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            entry_pending_q <= entry_pending_d;
            exit_pending_q  <= exit_pending_d;
            entry_pulse_q   <= entry_issue;
            exit_pulse_q    <= exit_issue;
            overrun_q       <= overrun_d;
        end
    end

    assign entry_pulse   = entry_pulse_q;
    assign exit_pulse    = exit_pulse_q;
    assign switch_out    = stable_q[1:0];
    assign entry_pending = entry_pending_q;
    assign exit_pending  = exit_pending_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_parking_sensor_conditioner.sv
// Directed bench for parking_sensor_conditioner: one instance with the default
// holdoff and one with a long holdoff for the overrun scenario.
module tb_parking_sensor_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       entry_raw = 1'b0;
    logic       exit_raw = 1'b0;
    logic [1:0] switch_raw = 2'b00;

    logic       entry_pulse, exit_pulse, entry_pending, exit_pending, overrun;
    logic [1:0] switch_out;
    logic       l_entry_pulse, l_exit_pulse, l_entry_pending, l_exit_pending, l_overrun;
    logic [1:0] l_switch_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    parking_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .entry_raw(entry_raw), .exit_raw(exit_raw),
        .switch_raw(switch_raw), .entry_pulse(entry_pulse), .exit_pulse(exit_pulse),
        .switch_out(switch_out), .entry_pending(entry_pending),
        .exit_pending(exit_pending), .overrun(overrun)
    );

    parking_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(20)) u_dut_long (
        .clk(clk), .rst(rst), .entry_raw(entry_raw), .exit_raw(exit_raw),
        .switch_raw(switch_raw), .entry_pulse(l_entry_pulse), .exit_pulse(l_exit_pulse),
        .switch_out(l_switch_out), .entry_pending(l_entry_pending),
        .exit_pending(l_exit_pending), .overrun(l_overrun)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d @%0t", tag, obs, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; entry_raw = 1'b0; exit_raw = 1'b0; switch_raw = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n_pulse;
        int n_ovr;

        // Reset state
        rst = 1'b1; entry_raw = 1'b1; exit_raw = 1'b1; switch_raw = 2'b11;
        tick();
        check("rst_entry_pulse", entry_pulse, 0);
        check("rst_exit_pulse", exit_pulse, 0);
        check("rst_switch_out", switch_out, 0);
        check("rst_entry_pending", entry_pending, 0);
        check("rst_exit_pending", exit_pending, 0);
        check("rst_overrun", overrun, 0);
        $display("txn reset: outputs checked");

        // 1: clean entry rise, latency
        do_reset();
        entry_raw = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            check($sformatf("t1_entry_pending_e%0d", k), entry_pending, (k == 5) ? 1 : 0);
            check($sformatf("t1_entry_pulse_e%0d", k), entry_pulse, (k == 6) ? 1 : 0);
            check($sformatf("t1_exit_pulse_e%0d", k), exit_pulse, 0);
        end
        $display("txn 1: entry rise latency");

        // 2: short glitch rejected, then exit step
        do_reset();
        entry_raw = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            tick();
            if (k == 2) entry_raw = 1'b0;
            check($sformatf("t2_glitch_pending_e%0d", k), entry_pending, 0);
            check($sformatf("t2_glitch_pulse_e%0d", k), entry_pulse, 0);
        end
        exit_raw = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            check($sformatf("t2_exit_pulse_e%0d", k), exit_pulse, (k == 6) ? 1 : 0);
            check($sformatf("t2_entry_pulse_e%0d", k), entry_pulse, 0);
        end
        $display("txn 2: glitch rejected, exit step");

        // 3: simultaneous rises, exit first then entry after holdoff
        do_reset();
        entry_raw = 1'b1; exit_raw = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            tick();
            check($sformatf("t3_exit_pulse_e%0d", k), exit_pulse, (k == 6) ? 1 : 0);
            check($sformatf("t3_entry_pulse_e%0d", k), entry_pulse, (k == 9) ? 1 : 0);
            check($sformatf("t3_exit_pending_e%0d", k), exit_pending, (k == 5) ? 1 : 0);
            check($sformatf("t3_entry_pending_e%0d", k), entry_pending,
                  (k >= 5 && k <= 8) ? 1 : 0);
        end
        $display("txn 3: simultaneous arbitration");

        // 4: long holdoff, two entry rises during HOLD merge with one overrun
        do_reset();
        exit_raw = 1'b1;
        n_pulse = 0;
        n_ovr = 0;
        for (int k = 0; k <= 34; k++) begin
            tick();
            check($sformatf("t4_exit_pulse_e%0d", k), l_exit_pulse, (k == 6) ? 1 : 0);
            check($sformatf("t4_entry_pulse_e%0d", k), l_entry_pulse, (k == 27) ? 1 : 0);
            check($sformatf("t4_overrun_e%0d", k), l_overrun, (k == 20) ? 1 : 0);
            check($sformatf("t4_entry_pending_e%0d", k), l_entry_pending,
                  (k >= 12 && k <= 26) ? 1 : 0);
            n_pulse += int'(l_entry_pulse);
            n_ovr   += int'(l_overrun);
            entry_raw = ((k + 1 >= 7 && k + 1 <= 10) || (k + 1 >= 15)) ? 1'b1 : 1'b0;
        end
        check("t4_entry_pulse_count", n_pulse, 1);
        check("t4_overrun_count", n_ovr, 1);
        $display("txn 4: holdoff merge pulses=%0d overruns=%0d", n_pulse, n_ovr);

        // 5: switch debounce and glitch rejection
        do_reset();
        switch_raw = 2'b10;
        for (int k = 0; k <= 7; k++) begin
            tick();
            check($sformatf("t5_switch_e%0d", k), switch_out, (k >= 5) ? 2 : 0);
        end
        switch_raw = 2'b11;
        tick();
        tick();
        switch_raw = 2'b10;
        for (int k = 0; k <= 8; k++) begin
            tick();
            check($sformatf("t5_switch_glitch_%0d", k), switch_out, 2);
        end
        $display("txn 5: switch debounce");

        // 6: reset while exit pending in HOLD discards it
        do_reset();
        entry_raw = 1'b1;
        tick();
        exit_raw = 1'b1;
        for (int k = 1; k <= 6; k++) tick();
        check("t6_entry_pulse_pre", entry_pulse, 1);
        check("t6_exit_pending_pre", exit_pending, 1);
        rst = 1'b1; entry_raw = 1'b0; exit_raw = 1'b0;
        tick();
        rst = 1'b0;
        check("t6_entry_pulse_rst", entry_pulse, 0);
        check("t6_exit_pulse_rst", exit_pulse, 0);
        check("t6_entry_pending_rst", entry_pending, 0);
        check("t6_exit_pending_rst", exit_pending, 0);
        check("t6_overrun_rst", overrun, 0);
        n_pulse = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_pulse += int'(exit_pulse) + int'(entry_pulse);
        end
        check("t6_no_pulse_after_rst", n_pulse, 0);
        $display("txn 6: mid-operation reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
